// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and index constants for the scan index generator
package scan_pkg;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  localparam int               IDX_W   = 3;
  localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;
  localparam logic [IDX_W-1:0] IDX_MIN = 3'd0;

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - modulo-DWELL counter with synchronous clear and terminal-count flag
module dwell_counter #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/scan_index_gen.sv
// rtl/scan_index_gen.sv - dwell-timed 0..7 index sequencer feeding the 3-to-8 decoder
// Optional down scanning is enabled by defining SCAN_DIR_EN.
module scan_index_gen
  import scan_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
`ifdef SCAN_DIR_EN
  input  logic             dir,
`endif
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  scan_state_t      state, state_n;
  logic [IDX_W-1:0] idx_n, idx_last, idx_step;
  logic             valid_n, busy_n, wrap_n, done_n;
  logic             mode_q, mode_n;
  logic             cnt_clr, cnt_tc;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (state == SCAN_RUN),
    .tc    (cnt_tc)
  );

`ifdef SCAN_DIR_EN
  logic dir_q, dir_n;
  assign idx_last = dir_q ? IDX_MIN : IDX_MAX;
  assign idx_step = dir_q ? idx - 3'd1 : idx + 3'd1;
`else
  assign idx_last = IDX_MAX;
  assign idx_step = idx + 3'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN_IDLE;
      idx       <= IDX_MIN;
      idx_valid <= 1'b0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
      mode_q    <= 1'b0;
`ifdef SCAN_DIR_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      idx_valid <= valid_n;
      busy      <= busy_n;
      wrap      <= wrap_n;
      done      <= done_n;
      mode_q    <= mode_n;
`ifdef SCAN_DIR_EN
      dir_q     <= dir_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = idx_valid;
    busy_n  = busy;
    wrap_n  = 1'b0;
    done_n  = 1'b0;
    mode_n  = mode_q;
    cnt_clr = 1'b0;
`ifdef SCAN_DIR_EN
    dir_n   = dir_q;
`endif
    unique case (state)
      SCAN_IDLE: begin
        // Holding the counter at zero while idle makes every RUN entry start a fresh dwell.
        cnt_clr = 1'b1;
        if (start && !stop) begin
          state_n = SCAN_RUN;
          mode_n  = mode;
          valid_n = 1'b1;
          busy_n  = 1'b1;
`ifdef SCAN_DIR_EN
          dir_n   = dir;
          idx_n   = dir ? IDX_MAX : IDX_MIN;
`else
          idx_n   = IDX_MIN;
`endif
        end
      end
      SCAN_RUN: begin
        if (stop) begin
          state_n = SCAN_IDLE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
        end else if (cnt_tc) begin
          if (idx == idx_last && mode_q) begin
            state_n = SCAN_IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n  = idx_step;
            wrap_n = (idx == idx_last);
          end
        end
      end
      default: state_n = SCAN_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scan_index_gen.sv
// tb/tb_scan_index_gen.sv - randomized check of two scan_index_gen instances against a timeline model
module tb_scan_index_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, mode = 1'b0, dir = 1'b0;

  logic [1:0][2:0] idx_w;
  logic [1:0]      valid_w, busy_w, wrap_w, done_w;

`ifdef SCAN_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  int dw [2] = '{10, 1};
  bit m_run [2];
  bit m_mode [2];
  bit m_dir [2];
  bit m_wrap [2];
  bit m_done [2];
  int m_t [2];
  int m_hold [2];

  always #5 clk = ~clk;

  scan_index_gen #(.DWELL(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
`ifdef SCAN_DIR_EN
    .dir(dir),
`endif
    .idx(idx_w[0]), .idx_valid(valid_w[0]), .busy(busy_w[0]), .wrap(wrap_w[0]), .done(done_w[0])
  );

  scan_index_gen #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
`ifdef SCAN_DIR_EN
    .dir(dir),
`endif
    .idx(idx_w[1]), .idx_valid(valid_w[1]), .busy(busy_w[1]), .wrap(wrap_w[1]), .done(done_w[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Index is a pure function of time since RUN entry: floor(t/DWELL) mod 8.
  function automatic int exp_idx(input int i);
    int p;
    if (!m_run[i]) return m_hold[i];
    p = (m_t[i] / dw[i]) % 8;
    return m_dir[i] ? 7 - p : p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_mode[i] = 0; m_dir[i] = 0; m_wrap[i] = 0;
      m_done[i] = 0; m_t[i] = 0; m_hold[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    m_wrap[i] = 0;
    m_done[i] = 0;
    if (!m_run[i]) begin
      if (start && !stop) begin
        m_run[i] = 1; m_t[i] = 0; m_mode[i] = mode; m_dir[i] = DIR_EN ? dir : 1'b0;
      end
    end else if (stop) begin
      m_hold[i] = exp_idx(i);
      m_run[i] = 0;
    end else if (m_mode[i] && m_t[i] == 8 * dw[i] - 1) begin
      m_run[i] = 0; m_done[i] = 1; m_hold[i] = m_dir[i] ? 0 : 7;
    end else begin
      m_t[i]++;
      m_wrap[i] = !m_mode[i] && (m_t[i] % (8 * dw[i]) == 0);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idx%0d", i), idx_w[i], exp_idx(i));
      chk($sformatf("valid%0d", i), valid_w[i], m_run[i]);
      chk($sformatf("busy%0d", i), busy_w[i], m_run[i]);
      chk($sformatf("wrap%0d", i), wrap_w[i], m_wrap[i]);
      chk($sformatf("done%0d", i), done_w[i], m_done[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic go(input bit md, input bit dr);
    start = 1; mode = md; dir = dr;
    tick();
    start = 0;
  endtask

  // Advance until the DWELL=10 instance shows the wanted index in RUN.
  task automatic wait_idx(input int want, input int budget);
    int k = 0;
    while (!(m_run[0] && exp_idx(0) == want) && k < budget) begin tick(); k++; end
    if (k >= budget) chk("wait_idx_timeout", 0, 1);
  endtask

  task automatic wait_t(input int want, input int budget);
    int k = 0;
    while (!(m_run[0] && m_t[0] == want) && k < budget) begin tick(); k++; end
    if (k >= budget) chk("wait_t_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    ticks(2);
    rst_n = 1;
    ticks(2);

    // single sweep up; mode toggled mid-run must be ignored
    go(1'b1, 1'b0);
    for (int k = 0; k < 85; k++) begin mode = $urandom_range(0, 1); tick(); end

    // continuous run, then stop at idx 3 of the DWELL=10 instance
    go(1'b0, 1'b0);
    ticks(90);
    wait_idx(3, 200);
    stop = 1; tick(); stop = 0;
    ticks(3);
    start = 1; stop = 1; tick(); tick(); start = 0; stop = 0;
    ticks(2);

    // stop on the final-dwell edge of a single sweep
    go(1'b1, 1'b0);
    wait_t(79, 200);
    stop = 1; tick(); stop = 0;
    ticks(3);

    // restart in the done cycle
    go(1'b1, 1'b0);
    wait_t(79, 200);
    tick();
    chk("done_seen", done_w[0], 1);
    go(1'b1, 1'b0);
    ticks(30);

`ifdef SCAN_DIR_EN
    stop = 1; tick(); stop = 0; tick();
    go(1'b1, 1'b1);
    for (int k = 0; k < 85; k++) begin dir = $urandom_range(0, 1); tick(); end
    go(1'b0, 1'b1);
    ticks(100);
`endif

    // asynchronous reset mid-scan at idx 5
    stop = 1; tick(); stop = 0; tick();
    go(1'b0, 1'b0);
    wait_idx(5, 200);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    ticks(2);
    #2 rst_n = 1;
    ticks(3);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      mode  = $urandom_range(0, 1);
      dir   = $urandom_range(0, 1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
